// File: rtl/alu_share_ctrl_pkg.sv
// Shared execute-stage defines: widths, ALU command encodings, flag positions
// and command-class helpers used by the ALU sharing controller.
package alu_share_ctrl_pkg;

  localparam int unsigned REGISTER_LEN        = 32;
  localparam int unsigned EXECUTE_COMMAND_LEN = 4;

  localparam logic [EXECUTE_COMMAND_LEN-1:0] NOP_EXE = 4'h0;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] ADD_EXE = 4'h1;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] ADC_EXE = 4'h2;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] SUB_EXE = 4'h3;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] SBC_EXE = 4'h4;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] AND_EXE = 4'h5;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] ORR_EXE = 4'h6;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EOR_EXE = 4'h7;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] MOV_EXE = 4'h8;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] MVN_EXE = 4'h9;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] CMP_EXE = 4'hA;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] TST_EXE = 4'hB;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] LDR_EXE = 4'hC;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] STR_EXE = 4'hD;

  // Bit positions inside the {Z,C,N,V} nibble
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  function automatic logic is_logical(input logic [EXECUTE_COMMAND_LEN-1:0] cmd);
    return (cmd == MOV_EXE) || (cmd == MVN_EXE) || (cmd == AND_EXE) ||
           (cmd == ORR_EXE) || (cmd == EOR_EXE) || (cmd == TST_EXE);
  endfunction

  function automatic logic is_compare(input logic [EXECUTE_COMMAND_LEN-1:0] cmd);
    return (cmd == CMP_EXE) || (cmd == TST_EXE);
  endfunction

  function automatic logic is_arith(input logic [EXECUTE_COMMAND_LEN-1:0] cmd);
    return (cmd == ADD_EXE) || (cmd == ADC_EXE) || (cmd == SUB_EXE) ||
           (cmd == SBC_EXE) || (cmd == CMP_EXE);
  endfunction

  function automatic logic is_mem(input logic [EXECUTE_COMMAND_LEN-1:0] cmd);
    return (cmd == LDR_EXE) || (cmd == STR_EXE);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on contention
// the requester that did not win the last transfer is granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       update_en,
  output logic [1:0] grant
);

  logic last_gnt;

  always_comb begin
    grant = '0;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_gnt ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  // Reset to 1 so port 0 wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (update_en) begin
      last_gnt <= grant[1];
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares the execute-stage ALU between two requesters, buffers one result
// and owns the architectural NZCV flags that feed the ALU carry-in.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REGISTER_LEN,
  parameter int unsigned CMD_W = EXECUTE_COMMAND_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [CMD_W-1:0] req_cmd0,
  input  logic [CMD_W-1:0] req_cmd1,
  input  logic [REG_W-1:0] req_a0,
  input  logic [REG_W-1:0] req_b0,
  input  logic [REG_W-1:0] req_a1,
  input  logic [REG_W-1:0] req_b1,
  input  logic [1:0]       req_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [REG_W-1:0] rsp_data,
  output logic [3:0]       rsp_flags,
  output logic [REG_W-1:0] alu_in1,
  output logic [REG_W-1:0] alu_in2,
  output logic [CMD_W-1:0] alu_command,
  output logic             alu_cin,
  input  logic [REG_W-1:0] alu_out,
  input  logic [3:0]       alu_status,
  output logic [3:0]       flags
);

  rsp_state_e state;
  logic [1:0] grant;
  logic       issue_ok;
  logic       xfer;
  logic       gnt_idx;
  logic [CMD_W-1:0] sel_cmd;
  logic [EXECUTE_COMMAND_LEN-1:0] cls_cmd;
  logic       sel_s;
  logic [3:0] flags_nxt;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req_valid),
    .update_en (xfer),
    .grant     (grant)
  );

  // rst_n gating keeps grants low during reset even though the state reads EMPTY
  assign issue_ok  = rst_n && ((state == RSP_EMPTY) || rsp_ready);
  assign req_ready = issue_ok ? grant : '0;
  assign xfer      = |req_ready;
  assign gnt_idx   = req_ready[1];

  assign sel_cmd = gnt_idx ? req_cmd1 : req_cmd0;
  assign sel_s   = gnt_idx ? req_s[1] : req_s[0];
  assign cls_cmd = EXECUTE_COMMAND_LEN'(sel_cmd);

  assign alu_in1     = gnt_idx ? req_a1 : req_a0;
  assign alu_in2     = gnt_idx ? req_b1 : req_b0;
  assign alu_command = xfer ? sel_cmd : CMD_W'(NOP_EXE);
  assign alu_cin     = flags[FLAG_C];

  assign rsp_valid = (state == RSP_FULL);

  // Compares always commit; loads/stores never touch the flags
  always_comb begin
    flags_nxt = flags;
    if (!is_mem(cls_cmd) && (sel_s || is_compare(cls_cmd))) begin
      if (is_arith(cls_cmd)) begin
        flags_nxt = alu_status;
      end else if (is_logical(cls_cmd)) begin
        flags_nxt[FLAG_Z] = alu_status[FLAG_Z];
        flags_nxt[FLAG_N] = alu_status[FLAG_N];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RSP_EMPTY;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      flags     <= '0;
    end else begin
      if (xfer) begin
        state     <= RSP_FULL;
        rsp_data  <= alu_out;
        rsp_flags <= alu_status;
        rsp_id    <= gnt_idx;
        flags     <= flags_nxt;
      end else if ((state == RSP_FULL) && rsp_ready) begin
        state <= RSP_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized bench for alu_share_ctrl with a behavioural ALU and a
// transaction-level reference model of arbitration, buffering and flags.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_cmd0, req_cmd1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_s;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_command, alu_status, flags;
  logic        alu_cin;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [3:0]  m_flags;
  logic        m_last, m_full, m_id;
  logic [31:0] m_data;
  logic [3:0]  m_rflags;

  always #5 clk = ~clk;

  alu_share_ctrl #(.REG_W(32), .CMD_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_s(req_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_command(alu_command), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_status(alu_status), .flags(flags)
  );

  // Behavioural ALU: returns {Z,C,N,V, result}; C on subtract is the borrow
  function automatic logic [35:0] alu_ref(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
    logic [32:0] w;
    logic [31:0] r;
    logic c, v;
    w = '0; c = 1'b0; v = 1'b0;
    case (cmd)
      ADD_EXE: w = {1'b0, a} + {1'b0, b};
      ADC_EXE: w = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      SUB_EXE, CMP_EXE: w = {1'b0, a} - {1'b0, b};
      SBC_EXE: w = {1'b0, a} - {1'b0, b} - {32'd0, cin};
      AND_EXE, TST_EXE: w = {1'b0, a & b};
      ORR_EXE: w = {1'b0, a | b};
      EOR_EXE: w = {1'b0, a ^ b};
      MOV_EXE: w = {1'b0, b};
      MVN_EXE: w = {1'b0, ~b};
      LDR_EXE, STR_EXE: w = {1'b0, a + b};
      default: w = '0;
    endcase
    r = w[31:0];
    if (cmd inside {ADD_EXE, ADC_EXE}) begin
      c = w[32];
      v = (a[31] == b[31]) && (r[31] != a[31]);
    end else if (cmd inside {SUB_EXE, SBC_EXE, CMP_EXE}) begin
      c = w[32];
      v = (a[31] != b[31]) && (r[31] != a[31]);
    end
    return {(r == 32'd0), c, r[31], v, r};
  endfunction

  always_comb {alu_status, alu_out} = alu_ref(alu_command, alu_in1, alu_in2, alu_cin);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flags = '0; m_last = 1'b1; m_full = 1'b0; m_id = 1'b0;
    m_data = '0; m_rflags = '0;
  endtask

  task automatic set_port(input int unsigned p, input logic [3:0] cmd,
                          input logic [31:0] a, input logic [31:0] b, input logic s);
    if (p == 0) begin
      req_cmd0 = cmd; req_a0 = a; req_b0 = b; req_s[0] = s;
    end else begin
      req_cmd1 = cmd; req_a1 = a; req_b1 = b; req_s[1] = s;
    end
  endtask

  // One clock cycle: check combinational grant/drive, then registered state
  task automatic step();
    logic        issue, gv, gi, s;
    logic [1:0]  exp_ready;
    logic [3:0]  cmd;
    logic [35:0] res;
    #1;
    issue = !m_full || rsp_ready;
    gv = 1'b0; gi = 1'b0;
    if (issue && req_valid == 2'b11) begin gv = 1'b1; gi = m_last ? 1'b0 : 1'b1; end
    else if (issue && req_valid[0]) begin gv = 1'b1; gi = 1'b0; end
    else if (issue && req_valid[1]) begin gv = 1'b1; gi = 1'b1; end
    exp_ready = gv ? (gi ? 2'b10 : 2'b01) : 2'b00;
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    check_eq("alu_cin", 32'(alu_cin), 32'(m_flags[2]));
    if (!gv) check_eq("alu_cmd_nop", 32'(alu_command), 32'(NOP_EXE));
    cmd = gi ? req_cmd1 : req_cmd0;
    s   = gi ? req_s[1] : req_s[0];
    res = alu_ref(cmd, gi ? req_a1 : req_a0, gi ? req_b1 : req_b0, m_flags[2]);
    @(posedge clk);
    #1;
    if (gv) begin
      m_full = 1'b1; m_id = gi; m_last = gi;
      m_data = res[31:0]; m_rflags = res[35:32];
      if (!(cmd inside {LDR_EXE, STR_EXE}) && (s || cmd inside {CMP_EXE, TST_EXE})) begin
        if (cmd inside {ADD_EXE, ADC_EXE, SUB_EXE, SBC_EXE, CMP_EXE})
          m_flags = res[35:32];
        else if (cmd inside {MOV_EXE, MVN_EXE, AND_EXE, ORR_EXE, EOR_EXE, TST_EXE}) begin
          m_flags[3] = res[35];
          m_flags[1] = res[33];
        end
      end
    end else if (m_full && rsp_ready) begin
      m_full = 1'b0;
    end
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_full));
    check_eq("flags", 32'(flags), 32'(m_flags));
    if (m_full) begin
      check_eq("rsp_data", rsp_data, m_data);
      check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
      check_eq("rsp_flags", 32'(rsp_flags), 32'(m_rflags));
    end
  endtask

  initial begin
    logic [31:0] held;
    logic [3:0]  rcmd;
    req_valid = 2'b11; rsp_ready = 1'b0; req_s = '0;
    set_port(0, NOP_EXE, 0, 0, 0);
    set_port(1, NOP_EXE, 0, 0, 0);
    model_reset();
    #1;
    check_eq("reset_req_ready", 32'(req_ready), 32'd0);
    check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset_rsp_data", rsp_data, 32'd0);
    check_eq("reset_flags", 32'(flags), 32'd0);
    req_valid = 2'b00;
    #7 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ADD with overflow into the sign bit
    set_port(0, ADD_EXE, 32'h7FFF_FFFF, 32'd1, 1'b1);
    req_valid = 2'b01; rsp_ready = 1'b1;
    step();
    check_eq("add_data", rsp_data, 32'h8000_0000);
    check_eq("add_id", 32'(rsp_id), 32'd0);
    check_eq("add_flags", 32'(flags), 32'b0011);

    // Backpressure: buffer held, no grant
    held = rsp_data;
    set_port(0, ADC_EXE, 32'd2, 32'd3, 1'b0);
    rsp_ready = 1'b0;
    repeat (3) begin
      step();
      check_eq("bp_hold", rsp_data, held);
    end
    rsp_ready = 1'b1;
    step();
    check_eq("bp_refill", rsp_data, 32'd5);

    // Reset while FULL clears outputs asynchronously
    rsp_ready = 1'b0; req_valid = 2'b11;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("midrst_rsp_data", rsp_data, 32'd0);
    check_eq("midrst_flags", 32'(flags), 32'd0);
    check_eq("midrst_req_ready", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention: grants alternate starting at port 0
    set_port(0, ADD_EXE, 32'd10, 32'd20, 1'b0);
    set_port(1, EOR_EXE, 32'hF0F0, 32'h0FF0, 1'b0);
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("contend_id", 32'(rsp_id), 32'(i % 2));
    end

    // Logical op keeps C from a prior subtract
    req_valid = 2'b01;
    set_port(0, SUB_EXE, 32'd0, 32'd1, 1'b1); step();
    set_port(0, MOV_EXE, 32'd0, 32'd0, 1'b1); step();
    check_eq("mov_flags", 32'(flags), 32'b1100);

    // CMP commits without S; LDR never commits
    set_port(0, CMP_EXE, 32'd5, 32'd5, 1'b0); step();
    check_eq("cmp_flags", 32'(flags), 32'b1000);
    set_port(0, LDR_EXE, 32'h100, 32'd4, 1'b1); step();
    check_eq("ldr_data", rsp_data, 32'h104);
    check_eq("ldr_flags", 32'(flags), 32'b1000);

    // ADC consumes a carry committed the cycle before
    set_port(0, SUB_EXE, 32'd0, 32'd1, 1'b1); step();
    set_port(0, ADC_EXE, 32'd1, 32'd1, 1'b0); step();
    check_eq("adc_data", rsp_data, 32'd3);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int unsigned p = 0; p < 2; p++) begin
        rcmd = 4'($urandom_range(0, 13));
        set_port(p, rcmd,
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                 1'($urandom_range(0, 1)));
      end
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing and sharing controller for the execute-stage ALU. It arbitrates between two requesters, the execute pipeline (port 0) and the address/compare helper (port 1), using round-robin priority. It drives the combinational ALU's operand and command inputs, registers its result into a single-entry response buffer, and owns the architectural NZCV flags register, which feeds the ALU carry-in.

## Interface
- `REG_W`, default 32: operand and result width (`REGISTER_LEN`).
- `CMD_W`, default 4: ALU command width (`EXECUTE_COMMAND_LEN`).
- Ports use one clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 2: per-requester request valid.
- `req_ready` out 2: per-requester grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_cmd0`, `req_cmd1` in CMD_W: execute command.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in REG_W: operands.
- `req_s` in 2: per-requester S-bit (update flags).
- `rsp_valid` out 1: response buffer holds a result.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: requester that owns the response.
- `rsp_data` out REG_W: registered ALU result.
- `rsp_flags` out 4: `{Z,C,N,V}` produced by this operation, raw ALU value.
- `alu_in1`, `alu_in2` out REG_W; `alu_command` out CMD_W; `alu_cin` out 1: drive the ALU.
- `alu_out` in REG_W; `alu_status` in 4: ALU result and `{Z,C,N,V}`.
- `flags` out 4: architectural `{Z,C,N,V}` register.

## Operation
- Two states:
  - EMPTY: buffer free.
  - FULL: `rsp_valid=1`.
- Issue is allowed when the state is EMPTY, or FULL with `rsp_ready=1` (drain and refill in the same cycle).
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester opposite to `last_gnt` is granted.
  - `last_gnt` updates only on an actual transfer.
  - At most one bit of `req_ready` is high.
  - `req_ready` depends on `req_valid`, `state`, `rsp_ready` and `last_gnt` only.
- ALU drive:
  - During a transfer, the granted operands and command are driven on `alu_*`.
  - `alu_cin = flags[2]` (C).
  - With no transfer, `alu_*` is held at the port-0 values and `alu_command` is forced to NOP (the ALU default, result 0).
- Capture at the transfer edge: `rsp_data←alu_out`, `rsp_flags←alu_status`, `rsp_id←grant index`, and the state becomes FULL.
- FULL with `rsp_ready=1` and no new transfer: the state becomes EMPTY.
- Flag commit happens at the capture edge when `req_s` is set for the granted port, or unconditionally for CMP/TST:
  - ADD/ADC/SUB/SBC/CMP: all four flags load from `alu_status`.
  - MOV/MVN/AND/ORR/EOR/TST: Z and N load; C and V are preserved.
  - LDR/STR: flags never change; `req_s` is ignored.
- Reset values:
  - `flags=0`, `last_gnt=1` so port 0 wins first.
  - State EMPTY, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `rsp_flags=0`.
  - `req_ready=0` while `rst_n=0`.
  - Reset mid-operation discards the buffered result with no flag commit.

## Timing
- Latency: request transfer in cycle N gives `rsp_valid` in cycle N+1.
- Throughput: one operation per cycle while `rsp_ready` stays high.
- Back-to-back flag dependency needs no stall: a flag commit at the end of N is visible as `alu_cin` in N+1.
- Backpressure:
  - FULL with `rsp_ready=0`: `req_ready=0`.
  - `rsp_*` is held stable until accepted.
- Requests may drop `req_valid` without a grant; there is no commitment before transfer.

## Structure
- Shared defines package holds `REGISTER_LEN`, `EXECUTE_COMMAND_LEN`, all `*_EXE` encodings, NOP encoding, and flag bit positions Z=3, C=2, N=1, V=0.
- Add a helper in the package: function "is_logical(cmd)" and "is_compare(cmd)".
- One natural sub-module: `rr_arb2` (2-way round-robin arbiter: valid in, grant out, update enable).
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Single request: port 0 issues ADD `0x7FFFFFFF + 1` with S=1. Next cycle `rsp_data=0x80000000`, `rsp_id=0`, `flags={0,0,1,1}`.
- Contention: both ports hold valid for 4 cycles with `rsp_ready=1`. Grants alternate 0,1,0,1; one response per cycle with matching `rsp_id`.
- Backpressure: `rsp_ready=0` for 3 cycles after a response. `req_ready=0` and `rsp_data` stays stable; on `rsp_ready=1` a new transfer occurs the same cycle.
- Logical flag preservation: SUB `0 - 1` with S=1 sets C=1, then MOV `0` with S=1. Result `flags={1,1,0,0}`: Z set, C kept.
- CMP without S, `5 - 5`: flags Z=1; then LDR `0x100 + 4` gives `rsp_data=0x104` with flags unchanged. ADC `1+1` after a C=1 commit gives 3.
- Assert `rst_n` low while FULL. Outputs clear asynchronously, no flag update; the first grant after release goes to port 0.
